// File: rtl/tone_synth.sv
// tone_synth
//
// Target-pitch tone generator for the pitch game. A request names an FFT bin
// (phase increment per sample) and a length in samples; the block then plays
// a triangle tone at that bin's centre frequency on the 4 kHz sample grid used
// by the detector. Samples are 12-bit unsigned ADC codes. An 8-bit PWM renders
// the current sample on the speaker pin.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   req_valid     in   request present
//   req_ready     out  request can be accepted (IDLE only, low during reset)
//   req_bin       in   [5:0]  bin index = phase increment per sample
//   req_len       in   [15:0] number of samples to emit
//   abort         in   terminate the current tone (no done pulse)
//   sample_out    out  [11:0] current sample, MIDSCALE when silent
//   sample_strobe out  one-cycle pulse in the cycle a tone sample is presented
//   busy          out  high while playing
//   done          out  one-cycle pulse on normal completion
//   pwm_out       out  PWM rendering of sample_out
module tone_synth #(
    parameter int          SAMPLE_DIV = 12500,
    parameter logic [11:0] MIDSCALE   = 12'd2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_bin,
    input  logic [15:0] req_len,
    input  logic        abort,
    output logic [11:0] sample_out,
    output logic        sample_strobe,
    output logic        busy,
    output logic        done,
    output logic        pwm_out
);

    localparam int                DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [5:0]        r_bin;
    logic [15:0]       r_len;
    logic [5:0]        r_phase;
    logic [15:0]       r_count;
    logic [DIV_W-1:0]  r_div;
    logic [11:0]       r_sample;
    logic              r_done;
    logic [7:0]        r_pwm_cnt;
    logic              r_pwm;

    logic              w_accept;
    logic              w_emit;
    logic              w_finish;
    logic              w_abort;

    // Triangle: ramps up over phases 0..31, back down over 32..63.
    // For p >= 32, 63-p equals the bitwise complement of the low five bits.
    function automatic logic [11:0] wave(input logic [5:0] p);
        logic [4:0] v_tri;
        v_tri = p[5] ? ~p[4:0] : p[4:0];
        return {v_tri, 7'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The completion decision is taken on the last divider count after the
    // final sample, so that done, busy=0 and req_ready=1 all appear together
    // on the cycle where the (len+1)-th tick would fall.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_emit       = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_len != 16'd0) begin
                        w_state_next = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (abort) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_div == '0 && r_count < r_len) begin
                    w_emit = 1'b1;
                end else if (r_div == DIV_LAST && r_count == r_len) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (r_state == S_IDLE) && !reset;
        busy          = (r_state == S_PLAY);
        done          = r_done;
        sample_strobe = w_emit && !reset;
        // The new sample is visible in its strobe cycle; r_sample holds it after.
        sample_out    = sample_strobe ? wave(r_phase) : r_sample;
        pwm_out       = r_pwm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin     <= 6'd0;
            r_len     <= 16'd0;
            r_phase   <= 6'd0;
            r_count   <= 16'd0;
            r_div     <= '0;
            r_sample  <= MIDSCALE;
            r_done    <= 1'b0;
            r_pwm_cnt <= 8'd0;
            r_pwm     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm     <= (r_pwm_cnt < sample_out[11:4]);

            if (w_accept) begin
                r_bin   <= req_bin;
                r_len   <= req_len;
                r_phase <= 6'd0;
                r_count <= 16'd0;
                r_div   <= '0;
                r_done  <= (req_len == 16'd0);
            end

            if (r_state == S_PLAY) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            end

            if (w_emit) begin
                r_sample <= wave(r_phase);
                r_phase  <= r_phase + r_bin;
                r_count  <= r_count + 16'd1;
            end

            if (w_finish) begin
                r_sample <= MIDSCALE;
                r_done   <= 1'b1;
            end

            if (w_abort) begin
                r_sample <= MIDSCALE;
            end
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Testbench for tone_synth with a 4-cycle sample period. A cycle-level
// behavioural model derives every output from the request timeline
// (acceptance cycle, bin, length, abort cycle) and is compared each cycle.
// Directed scenarios also post literal expectations that the compare process
// judges alongside the model.
module tb_tone_synth;

    localparam int DIV = 4;
    localparam int MID = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_bin = 6'd0;
    logic [15:0] req_len = 16'd0;
    logic        abort = 1'b0;
    logic [11:0] sample_out;
    logic        sample_strobe;
    logic        busy;
    logic        done;
    logic        pwm_out;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    string lq_name[$];
    int    lq_act[$];
    int    lq_exp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tone_synth #(.SAMPLE_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bin      (req_bin),
        .req_len      (req_len),
        .abort        (abort),
        .sample_out   (sample_out),
        .sample_strobe(sample_strobe),
        .busy         (busy),
        .done         (done),
        .pwm_out      (pwm_out)
    );

    function automatic int wave_m(input int p);
        int q;
        q = p % 64;
        return ((q < 32) ? q : 63 - q) * 128;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Literal expectation sampled by the stimulus; judged at the next negedge.
    task automatic want(input string name, input int act, input int exp);
        lq_name.push_back(name);
        lq_act.push_back(act);
        lq_exp.push_back(exp);
    endtask

    // Compare process: behavioural model + literal queue, once per cycle.
    initial begin : compare
        int  t, end_c, rel, k, last;
        int  e_ready, e_busy, e_strobe, e_done, e_samp, e_pwm;
        bit  tx_on, have_prev;
        int  tx_a, tx_bin, tx_len, tx_abort, prev_cnt, prev_samp;
        tx_on = 0; have_prev = 0; tx_a = 0; tx_bin = 0; tx_len = 0;
        tx_abort = -1; prev_cnt = 0; prev_samp = MID;
        forever begin
            @(negedge clk);
            t = cyc;
            while (lq_name.size() > 0)
                chk(lq_name.pop_front(), lq_act.pop_front(), lq_exp.pop_front());
            if (reset) begin
                chk("ready_in_reset", int'(req_ready), 0);
                chk("strobe_in_reset", int'(sample_strobe), 0);
                tx_on = 0;
                have_prev = 0;
            end else begin
                e_ready = 1; e_busy = 0; e_strobe = 0; e_done = 0; e_samp = MID;
                if (tx_on) begin
                    end_c = tx_a + 1 + tx_len * DIV;
                    if (tx_abort >= 0 && t > tx_abort) begin
                        tx_on = 0;
                    end else if (t == end_c) begin
                        e_done = 1;
                    end else if (t > end_c) begin
                        tx_on = 0;
                    end else begin
                        if (abort) tx_abort = t;
                        rel      = t - tx_a - 1;
                        k        = rel / DIV;
                        e_ready  = 0;
                        e_busy   = 1;
                        e_strobe = (rel % DIV == 0 && !abort) ? 1 : 0;
                        last     = (e_strobe == 1) ? k : ((rel % DIV == 0) ? k - 1 : k);
                        e_samp   = (last < 0) ? MID : wave_m(last * tx_bin);
                    end
                end
                e_pwm = have_prev ? ((prev_cnt < (prev_samp >> 4)) ? 1 : 0) : 0;
                chk("req_ready", int'(req_ready), e_ready);
                chk("busy", int'(busy), e_busy);
                chk("sample_strobe", int'(sample_strobe), e_strobe);
                chk("done", int'(done), e_done);
                chk("sample_out", int'(sample_out), e_samp);
                chk("pwm_out", int'(pwm_out), e_pwm);
                prev_cnt  = have_prev ? (prev_cnt + 1) % 256 : 0;
                prev_samp = e_samp;
                have_prev = 1;
                if (e_ready == 1 && req_valid) begin
                    tx_on = 1; tx_a = t; tx_bin = int'(req_bin);
                    tx_len = int'(req_len); tx_abort = -1;
                end
            end
        end
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input int bin, input int len, output int a);
        a = cyc;
        req_valid = 1'b1;
        req_bin   = 6'(bin);
        req_len   = 16'(len);
    endtask

    initial begin : stimulus
        int a, n;
        go(3);
        reset = 1'b0;
        #2;
        want("rst_ready", int'(req_ready), 1);
        want("rst_busy", int'(busy), 0);
        want("rst_sample", int'(sample_out), 2048);
        want("rst_pwm", int'(pwm_out), 0);

        // bin=1, len=4
        go(5);
        request(1, 4, a);
        go(a + 1); req_valid = 1'b0; #2;
        want("t1_s0_strobe", int'(sample_strobe), 1);
        want("t1_s0", int'(sample_out), 0);
        go(a + 5);  #2; want("t1_s1", int'(sample_out), 128);
        go(a + 9);  #2; want("t1_s2", int'(sample_out), 256);
        go(a + 13); #2; want("t1_s3", int'(sample_out), 384);
        go(a + 17); #2;
        want("t1_done", int'(done), 1);
        want("t1_ready", int'(req_ready), 1);
        want("t1_idle_sample", int'(sample_out), 2048);

        // bin=16, len=4
        go(a + 20);
        request(16, 4, a);
        go(a + 1); req_valid = 1'b0;
        go(a + 5);  #2; want("t2_s1", int'(sample_out), 2048);
        go(a + 9);  #2; want("t2_s2", int'(sample_out), 3968);
        go(a + 13); #2; want("t2_s3", int'(sample_out), 1920);
        go(a + 17); #2; want("t2_done", int'(done), 1);

        // len=0
        go(a + 20);
        request(7, 0, a);
        go(a + 1); req_valid = 1'b0; #2;
        want("t3_done", int'(done), 1);
        want("t3_busy", int'(busy), 0);
        want("t3_strobe", int'(sample_strobe), 0);

        // bin=40, len=70: phase wrap and strobe count
        go(a + 4);
        request(40, 70, a);
        n = 0;
        for (int c = a + 1; c <= a + 70 * DIV; c++) begin
            go(c);
            req_valid = 1'b0;
            #2;
            n += int'(sample_strobe);
            if (c == a + 5) want("t4_s1", int'(sample_out), 2944);
            if (c == a + 9) want("t4_s2", int'(sample_out), 2048);
        end
        want("t4_strobes", n, 70);
        go(a + 1 + 70 * DIV); #2; want("t4_done", int'(done), 1);

        // abort between ticks
        go(a + 1 + 70 * DIV + 3);
        request(1, 4, a);
        n = 0;
        for (int c = a + 1; c <= a + 6; c++) begin
            go(c);
            req_valid = 1'b0;
            abort = (c == a + 6);
            #2;
            n += int'(sample_strobe);
        end
        go(a + 7); abort = 1'b0; #2;
        want("t5_strobes", n, 2);
        want("t5_busy", int'(busy), 0);
        want("t5_sample", int'(sample_out), 2048);
        go(a + 17); #2; want("t5_no_done", int'(done), 0);

        // abort coincident with a tick
        go(a + 19);
        request(1, 4, a);
        go(a + 1); req_valid = 1'b0;
        go(a + 9); abort = 1'b1; #2;
        want("t6_strobe", int'(sample_strobe), 0);
        want("t6_hold", int'(sample_out), 128);
        go(a + 10); abort = 1'b0; #2;
        want("t6_busy", int'(busy), 0);
        want("t6_sample", int'(sample_out), 2048);

        // request held high through PLAY: accepted on the done cycle
        go(a + 12);
        request(2, 3, a);
        go(a + 1); req_bin = 6'd3; req_len = 16'd2;
        go(a + 5);  #2; want("t7_s1", int'(sample_out), 256);
        go(a + 13); #2;
        want("t7_done", int'(done), 1);
        want("t7_ready", int'(req_ready), 1);
        go(a + 14); req_valid = 1'b0; #2;
        want("t7_next_busy", int'(busy), 1);
        want("t7_next_s0", int'(sample_strobe), 1);
        go(a + 18); #2; want("t7_next_s1", int'(sample_out), 384);

        // reset mid-PLAY with a held request
        go(a + 30);
        request(5, 10, a);
        go(a + 1); req_bin = 6'd9; req_len = 16'd2;
        go(a + 10); reset = 1'b1;
        go(a + 11); reset = 1'b0; #2;
        want("t8_busy", int'(busy), 0);
        want("t8_done", int'(done), 0);
        want("t8_sample", int'(sample_out), 2048);
        want("t8_pwm", int'(pwm_out), 0);
        want("t8_ready", int'(req_ready), 1);
        go(a + 12); req_valid = 1'b0; #2;
        want("t8_reaccept", int'(busy), 1);

        // maximal length, cut short by abort
        go(a + 25);
        request(63, 65535, a);
        go(a + 1); req_valid = 1'b0; #2;
        want("t9_busy", int'(busy), 1);
        go(a + 300); abort = 1'b1;
        go(a + 301); abort = 1'b0; #2;
        want("t9_aborted", int'(busy), 0);

        // PWM duty at MIDSCALE
        go(a + 304);
        n = 0;
        for (int c = a + 304; c < a + 304 + 256; c++) begin
            go(c);
            #2;
            n += int'(pwm_out);
        end
        want("pwm_mid_duty", n, 128);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            go(cyc + 1);
            reset     = ($urandom % 800 == 0);
            req_valid = ($urandom % 5 == 0);
            req_bin   = 6'($urandom);
            req_len   = ($urandom % 6 == 0) ? 16'd0 : 16'($urandom_range(1, 10));
            abort     = ($urandom % 60 == 0);
        end
        go(cyc + 1);
        reset = 1'b0; req_valid = 1'b0; abort = 1'b0;
        go(cyc + 50);
        go(cyc + 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
